// File: rtl/tl_a_arbiter_2to1.sv
// Two-client TL-UL A-channel arbiter: round-robin on message boundaries, locks
// for multi-beat Put bursts, caps per-client outstanding, routes D by source MSB.
module tl_a_arbiter_2to1 #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned SRC_W   = 2,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a0_valid,
  output logic                  a0_ready,
  input  logic [2:0]            a0_opcode,
  input  logic [2:0]            a0_param,
  input  logic [2:0]            a0_size,
  input  logic [SRC_W-1:0]      a0_source,
  input  logic [ADDR_W-1:0]     a0_address,
  input  logic [DATA_W/8-1:0]   a0_mask,
  input  logic [DATA_W-1:0]     a0_data,
  input  logic                  a1_valid,
  output logic                  a1_ready,
  input  logic [2:0]            a1_opcode,
  input  logic [2:0]            a1_param,
  input  logic [2:0]            a1_size,
  input  logic [SRC_W-1:0]      a1_source,
  input  logic [ADDR_W-1:0]     a1_address,
  input  logic [DATA_W/8-1:0]   a1_mask,
  input  logic [DATA_W-1:0]     a1_data,
  output logic                  out_a_valid,
  input  logic                  out_a_ready,
  output logic [2:0]            out_a_opcode,
  output logic [2:0]            out_a_param,
  output logic [2:0]            out_a_size,
  output logic [SRC_W:0]        out_a_source,
  output logic [ADDR_W-1:0]     out_a_address,
  output logic [DATA_W/8-1:0]   out_a_mask,
  output logic [DATA_W-1:0]     out_a_data,
  input  logic                  out_d_valid,
  output logic                  out_d_ready,
  input  logic [2:0]            out_d_opcode,
  input  logic [2:0]            out_d_size,
  input  logic [SRC_W:0]        out_d_source,
  input  logic                  out_d_denied,
  input  logic [DATA_W-1:0]     out_d_data,
  output logic                  d0_valid,
  input  logic                  d0_ready,
  output logic [2:0]            d0_opcode,
  output logic [2:0]            d0_size,
  output logic [SRC_W-1:0]      d0_source,
  output logic                  d0_denied,
  output logic [DATA_W-1:0]     d0_data,
  output logic                  d1_valid,
  input  logic                  d1_ready,
  output logic [2:0]            d1_opcode,
  output logic [2:0]            d1_size,
  output logic [SRC_W-1:0]      d1_source,
  output logic                  d1_denied,
  output logic [DATA_W-1:0]     d1_data,
  output logic                  err_unexpected_d
);

  localparam int unsigned BB      = DATA_W / 8;
  localparam int unsigned BB_LOG2 = $clog2(BB);
  localparam logic [3:0]  MAX_C   = 4'(MAX_OUT);

  typedef enum logic {ST_IDLE, ST_BURST} arb_state_e;

  arb_state_e  state_q, state_d;
  logic        lock_idx_q, lock_idx_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [7:0]  a_beats_left_q, a_beats_left_d;
  logic [7:0]  d_beats_left_q, d_beats_left_d;
  logic [3:0]  out_cnt0_q, out_cnt0_d;
  logic [3:0]  out_cnt1_q, out_cnt1_d;
  logic        err_q, err_d;

  logic        elig0, elig1, grant, a_avail, a_fire, a_last;
  logic [7:0]  a_beats, d_beats;
  logic        d_sel, d_fire, d_last;
  logic        inc0, inc1, dec0, dec1;

  function automatic logic [7:0] beats_of(input logic has_data, input logic [2:0] size);
    logic [8:0] bytes;
    bytes = 9'd1 << size;
    if (has_data && (bytes > 9'(BB))) return 8'(bytes >> BB_LOG2);
    return 8'd1;
  endfunction

  // Grant and handshake; eligibility only gates new messages, never a locked burst.
  always_comb begin
    elig0 = a0_valid && (out_cnt0_q < MAX_C);
    elig1 = a1_valid && (out_cnt1_q < MAX_C);
    grant   = 1'b0;
    a_avail = 1'b0;
    if (state_q == ST_BURST) begin
      grant   = lock_idx_q;
      a_avail = lock_idx_q ? a1_valid : a0_valid;
    end else begin
      grant   = (elig0 && elig1) ? rr_ptr_q : elig1;
      a_avail = elig0 || elig1;
    end

    out_a_valid   = a_avail && !reset;
    out_a_opcode  = grant ? a1_opcode  : a0_opcode;
    out_a_param   = grant ? a1_param   : a0_param;
    out_a_size    = grant ? a1_size    : a0_size;
    out_a_source  = {grant, (grant ? a1_source : a0_source)};
    out_a_address = grant ? a1_address : a0_address;
    out_a_mask    = grant ? a1_mask    : a0_mask;
    out_a_data    = grant ? a1_data    : a0_data;

    a0_ready = !reset && out_a_ready && !grant && ((state_q == ST_BURST) || a_avail);
    a1_ready = !reset && out_a_ready &&  grant && ((state_q == ST_BURST) || a_avail);

    a_fire  = out_a_valid && out_a_ready;
    a_beats = beats_of(out_a_opcode[2:1] == 2'b00, out_a_size);
    a_last  = (state_q == ST_IDLE) ? (a_beats == 8'd1) : (a_beats_left_q == 8'd1);
  end

  always_comb begin
    d_sel       = out_d_source[SRC_W];
    out_d_ready = !reset && (d_sel ? d1_ready : d0_ready);
    d0_valid    = !reset && out_d_valid && !d_sel;
    d1_valid    = !reset && out_d_valid &&  d_sel;
    d0_opcode   = out_d_opcode;
    d1_opcode   = out_d_opcode;
    d0_size     = out_d_size;
    d1_size     = out_d_size;
    d0_source   = out_d_source[SRC_W-1:0];
    d1_source   = out_d_source[SRC_W-1:0];
    d0_denied   = out_d_denied;
    d1_denied   = out_d_denied;
    d0_data     = out_d_data;
    d1_data     = out_d_data;

    d_fire  = out_d_valid && out_d_ready;
    d_beats = beats_of(out_d_opcode == 3'd1, out_d_size);
    // A zero counter means "first beat next"; the last beat is the one leaving zero behind.
    d_last  = (d_beats_left_q == 8'd0) ? (d_beats == 8'd1) : (d_beats_left_q == 8'd1);
  end

  always_comb begin
    state_d        = state_q;
    lock_idx_d     = lock_idx_q;
    rr_ptr_d       = rr_ptr_q;
    a_beats_left_d = a_beats_left_q;
    d_beats_left_d = d_beats_left_q;
    out_cnt0_d     = out_cnt0_q;
    out_cnt1_d     = out_cnt1_q;
    err_d          = err_q;

    if (a_fire) begin
      if (state_q == ST_IDLE) begin
        if (!a_last) begin
          state_d        = ST_BURST;
          lock_idx_d     = grant;
          a_beats_left_d = a_beats - 8'd1;
        end
      end else begin
        a_beats_left_d = a_beats_left_q - 8'd1;
        if (a_last) state_d = ST_IDLE;
      end
      if (a_last) rr_ptr_d = ~grant;
    end

    if (d_fire) begin
      d_beats_left_d = (d_beats_left_q == 8'd0) ? (d_beats - 8'd1) : (d_beats_left_q - 8'd1);
      if ((d_sel ? out_cnt1_q : out_cnt0_q) == 4'd0) err_d = 1'b1;
    end

    inc0 = a_fire && (state_q == ST_IDLE) && !grant;
    inc1 = a_fire && (state_q == ST_IDLE) &&  grant;
    dec0 = d_fire && d_last && !d_sel && (out_cnt0_q != 4'd0);
    dec1 = d_fire && d_last &&  d_sel && (out_cnt1_q != 4'd0);
    if (inc0 && !dec0) out_cnt0_d = out_cnt0_q + 4'd1;
    if (!inc0 && dec0) out_cnt0_d = out_cnt0_q - 4'd1;
    if (inc1 && !dec1) out_cnt1_d = out_cnt1_q + 4'd1;
    if (!inc1 && dec1) out_cnt1_d = out_cnt1_q - 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      lock_idx_q     <= 1'b0;
      rr_ptr_q       <= 1'b0;
      a_beats_left_q <= '0;
      d_beats_left_q <= '0;
      out_cnt0_q     <= '0;
      out_cnt1_q     <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      lock_idx_q     <= lock_idx_d;
      rr_ptr_q       <= rr_ptr_d;
      a_beats_left_q <= a_beats_left_d;
      d_beats_left_q <= d_beats_left_d;
      out_cnt0_q     <= out_cnt0_d;
      out_cnt1_q     <= out_cnt1_d;
      err_q          <= err_d;
    end
  end

  assign err_unexpected_d = err_q;

endmodule

// File: tb/tb_tl_a_arbiter_2to1.sv
// Directed vector bench for tl_a_arbiter_2to1 (default parameters, MAX_OUT = 2).
module tb_tl_a_arbiter_2to1;

  localparam logic [2:0] GET  = 3'd4;
  localparam logic [2:0] PUTF = 3'd0;
  localparam logic [2:0] ACK  = 3'd0;
  localparam logic [2:0] ACKD = 3'd1;
  localparam logic [31:0] A0_ADDR = 32'h0000_1000;
  localparam logic [31:0] A1_ADDR = 32'h0000_2000;
  localparam logic [31:0] D_DATA  = 32'hD00D_F00D;

  typedef struct {
    logic       rst;
    logic       a0v; logic [2:0] a0op; logic [2:0] a0sz;
    logic       a1v; logic [2:0] a1op; logic [2:0] a1sz;
    logic       oar;
    logic       dv;  logic [2:0] dop;  logic [2:0] dsz; logic [2:0] dsrc;
    logic       d0r; logic d1r;
    logic       e_a0r; logic e_a1r; logic e_oav; logic [2:0] e_src;
    logic       e_odr; logic e_d0v; logic e_d1v; logic e_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic a0_valid, a0_ready, a1_valid, a1_ready;
  logic [2:0] a0_opcode, a0_param, a0_size, a1_opcode, a1_param, a1_size;
  logic [1:0] a0_source, a1_source;
  logic [31:0] a0_address, a1_address, a0_data, a1_data;
  logic [3:0] a0_mask, a1_mask;
  logic out_a_valid, out_a_ready;
  logic [2:0] out_a_opcode, out_a_param, out_a_size, out_a_source;
  logic [31:0] out_a_address, out_a_data;
  logic [3:0] out_a_mask;
  logic out_d_valid, out_d_ready, out_d_denied;
  logic [2:0] out_d_opcode, out_d_size, out_d_source;
  logic [31:0] out_d_data;
  logic d0_valid, d0_ready, d0_denied, d1_valid, d1_ready, d1_denied;
  logic [2:0] d0_opcode, d0_size, d1_opcode, d1_size;
  logic [1:0] d0_source, d1_source;
  logic [31:0] d0_data, d1_data;
  logic err_unexpected_d;

  int n_vec = 0;
  int n_mis = 0;
  vec_t tbl [21];
  vec_t s;

  always #5 clk = ~clk;

  tl_a_arbiter_2to1 #(.DATA_W(32), .ADDR_W(32), .SRC_W(2), .MAX_OUT(2)) dut (
    .clock(clk), .reset(reset),
    .a0_valid(a0_valid), .a0_ready(a0_ready), .a0_opcode(a0_opcode), .a0_param(a0_param),
    .a0_size(a0_size), .a0_source(a0_source), .a0_address(a0_address), .a0_mask(a0_mask),
    .a0_data(a0_data),
    .a1_valid(a1_valid), .a1_ready(a1_ready), .a1_opcode(a1_opcode), .a1_param(a1_param),
    .a1_size(a1_size), .a1_source(a1_source), .a1_address(a1_address), .a1_mask(a1_mask),
    .a1_data(a1_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_denied(out_d_denied),
    .out_d_data(out_d_data),
    .d0_valid(d0_valid), .d0_ready(d0_ready), .d0_opcode(d0_opcode), .d0_size(d0_size),
    .d0_source(d0_source), .d0_denied(d0_denied), .d0_data(d0_data),
    .d1_valid(d1_valid), .d1_ready(d1_ready), .d1_opcode(d1_opcode), .d1_size(d1_size),
    .d1_source(d1_source), .d1_denied(d1_denied), .d1_data(d1_data),
    .err_unexpected_d(err_unexpected_d)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_mis++;
      $display("FAIL vec %0d %s: got %h expected %h", n_vec, name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then compare before the next rising edge.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    reset        = v.rst;
    a0_valid     = v.a0v; a0_opcode = v.a0op; a0_size = v.a0sz;
    a1_valid     = v.a1v; a1_opcode = v.a1op; a1_size = v.a1sz;
    out_a_ready  = v.oar;
    out_d_valid  = v.dv;  out_d_opcode = v.dop; out_d_size = v.dsz; out_d_source = v.dsrc;
    d0_ready     = v.d0r; d1_ready = v.d1r;
    #2;
    chk("a0_ready", 32'(a0_ready), 32'(v.e_a0r));
    chk("a1_ready", 32'(a1_ready), 32'(v.e_a1r));
    chk("out_a_valid", 32'(out_a_valid), 32'(v.e_oav));
    chk("out_d_ready", 32'(out_d_ready), 32'(v.e_odr));
    chk("d0_valid", 32'(d0_valid), 32'(v.e_d0v));
    chk("d1_valid", 32'(d1_valid), 32'(v.e_d1v));
    chk("err_unexpected_d", 32'(err_unexpected_d), 32'(v.e_err));
    if (v.e_oav) begin
      chk("out_a_source", 32'(out_a_source), 32'(v.e_src));
      chk("out_a_address", out_a_address, v.e_src[2] ? A1_ADDR : A0_ADDR);
      chk("out_a_opcode", 32'(out_a_opcode), 32'(v.e_src[2] ? v.a1op : v.a0op));
    end
    if (v.e_d0v) begin
      chk("d0_source", 32'(d0_source), 32'(v.dsrc[1:0]));
      chk("d0_data", d0_data, D_DATA);
    end
    if (v.e_d1v) begin
      chk("d1_source", 32'(d1_source), 32'(v.dsrc[1:0]));
      chk("d1_data", d1_data, D_DATA);
    end
    n_vec++;
  endtask

  initial begin
    reset = 1'b1;
    a0_valid = 1'b0; a0_opcode = GET; a0_param = 3'd0; a0_size = 3'd2; a0_source = 2'd1;
    a0_address = A0_ADDR; a0_mask = 4'hF; a0_data = 32'hA0A0_A0A0;
    a1_valid = 1'b0; a1_opcode = GET; a1_param = 3'd0; a1_size = 3'd2; a1_source = 2'd2;
    a1_address = A1_ADDR; a1_mask = 4'hF; a1_data = 32'hB1B1_B1B1;
    out_a_ready = 1'b0;
    out_d_valid = 1'b0; out_d_opcode = ACK; out_d_size = 3'd2; out_d_source = 3'd0;
    out_d_denied = 1'b0; out_d_data = D_DATA;
    d0_ready = 1'b1; d1_ready = 1'b1;

    //          rst a0v a0op a0sz a1v a1op a1sz oar dv dop  dsz  dsrc   d0r d1r a0r a1r oav src     odr d0v d1v err
    tbl[0]  = '{1, 1, GET,  2, 1, GET,  2, 1, 1, ACK,  2, 3'b100, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, GET,  2, 1, GET,  2, 1, 0, ACK,  2, 3'b000, 1, 1, 1, 0, 1, 3'b001, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, GET,  2, 1, GET,  2, 1, 0, ACK,  2, 3'b000, 1, 1, 0, 1, 1, 3'b110, 1, 0, 0, 0};
    tbl[3]  = '{0, 1, GET,  2, 0, GET,  2, 0, 0, ACK,  2, 3'b000, 1, 1, 0, 0, 1, 3'b001, 1, 0, 0, 0};
    tbl[4]  = '{0, 1, GET,  2, 0, GET,  2, 1, 0, ACK,  2, 3'b000, 1, 1, 1, 0, 1, 3'b001, 1, 0, 0, 0};
    tbl[5]  = '{0, 1, GET,  2, 0, GET,  2, 1, 1, ACK,  2, 3'b000, 1, 1, 0, 0, 0, 3'b000, 1, 1, 0, 0};
    tbl[6]  = '{0, 1, GET,  2, 0, GET,  2, 1, 0, ACK,  2, 3'b000, 1, 1, 1, 0, 1, 3'b001, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, GET,  2, 1, GET,  2, 1, 0, ACK,  2, 3'b000, 1, 1, 0, 1, 1, 3'b110, 1, 0, 0, 0};
    tbl[8]  = '{0, 0, GET,  2, 1, GET,  2, 1, 1, ACKD, 4, 3'b101, 1, 0, 0, 0, 0, 3'b000, 0, 0, 1, 0};
    tbl[9]  = '{0, 0, GET,  2, 1, GET,  2, 1, 1, ACKD, 4, 3'b101, 1, 1, 0, 0, 0, 3'b000, 1, 0, 1, 0};
    tbl[10] = '{0, 0, GET,  2, 1, GET,  2, 1, 1, ACKD, 4, 3'b101, 1, 1, 0, 0, 0, 3'b000, 1, 0, 1, 0};
    tbl[11] = '{0, 0, GET,  2, 1, GET,  2, 1, 1, ACKD, 4, 3'b101, 1, 1, 0, 0, 0, 3'b000, 1, 0, 1, 0};
    tbl[12] = '{0, 0, GET,  2, 1, GET,  2, 1, 1, ACKD, 4, 3'b101, 1, 1, 0, 0, 0, 3'b000, 1, 0, 1, 0};
    tbl[13] = '{0, 0, GET,  2, 1, GET,  2, 1, 0, ACK,  2, 3'b000, 1, 1, 0, 1, 1, 3'b110, 1, 0, 0, 0};
    tbl[14] = '{1, 1, PUTF, 4, 1, GET,  2, 1, 1, ACK,  2, 3'b000, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0};
    tbl[15] = '{0, 1, PUTF, 4, 1, GET,  2, 1, 0, ACK,  2, 3'b000, 1, 1, 1, 0, 1, 3'b001, 1, 0, 0, 0};
    tbl[16] = '{0, 1, PUTF, 4, 1, GET,  2, 1, 0, ACK,  2, 3'b000, 1, 1, 1, 0, 1, 3'b001, 1, 0, 0, 0};
    tbl[17] = '{0, 1, PUTF, 4, 1, GET,  2, 0, 0, ACK,  2, 3'b000, 1, 1, 0, 0, 1, 3'b001, 1, 0, 0, 0};
    tbl[18] = '{0, 1, PUTF, 4, 1, GET,  2, 1, 0, ACK,  2, 3'b000, 1, 1, 1, 0, 1, 3'b001, 1, 0, 0, 0};
    tbl[19] = '{0, 1, PUTF, 4, 1, GET,  2, 1, 0, ACK,  2, 3'b000, 1, 1, 1, 0, 1, 3'b001, 1, 0, 0, 0};
    tbl[20] = '{0, 1, PUTF, 4, 1, GET,  2, 1, 0, ACK,  2, 3'b000, 1, 1, 0, 1, 1, 3'b110, 1, 0, 0, 0};

    for (int i = 0; i < 21; i++) run_vec(tbl[i]);

    // Reset dropped in the middle of an r1 burst: no residual lock afterwards.
    s = '{1, 0, GET, 2, 0, PUTF, 4, 1, 0, ACK, 2, 3'b000, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0}; run_vec(s);
    s = '{0, 0, GET, 2, 1, PUTF, 4, 1, 0, ACK, 2, 3'b000, 1, 1, 0, 1, 1, 3'b110, 1, 0, 0, 0}; run_vec(s);
    run_vec(s);
    s = '{1, 1, GET, 2, 1, PUTF, 4, 1, 1, ACK, 2, 3'b100, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0}; run_vec(s);
    run_vec(s);
    s = '{0, 1, GET, 2, 1, PUTF, 4, 1, 0, ACK, 2, 3'b000, 1, 1, 1, 0, 1, 3'b001, 1, 0, 0, 0}; run_vec(s);
    s = '{0, 1, GET, 2, 1, PUTF, 4, 1, 0, ACK, 2, 3'b000, 1, 1, 0, 1, 1, 3'b110, 1, 0, 0, 0}; run_vec(s);

    // Unexpected D to r0: flag is sticky until reset.
    s = '{1, 0, GET, 2, 0, GET, 2, 1, 0, ACK, 2, 3'b000, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0}; run_vec(s);
    s = '{0, 0, GET, 2, 0, GET, 2, 1, 1, ACK, 2, 3'b000, 1, 1, 0, 0, 0, 3'b000, 1, 1, 0, 0}; run_vec(s);
    s = '{0, 0, GET, 2, 0, GET, 2, 1, 0, ACK, 2, 3'b000, 1, 1, 0, 0, 0, 3'b000, 1, 0, 0, 1};
    for (int i = 0; i < 3; i++) run_vec(s);
    s = '{1, 0, GET, 2, 0, GET, 2, 1, 0, ACK, 2, 3'b000, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 1}; run_vec(s);
    s = '{0, 0, GET, 2, 0, GET, 2, 1, 0, ACK, 2, 3'b000, 1, 1, 0, 0, 0, 3'b000, 1, 0, 0, 0}; run_vec(s);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
